mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore-style sequencing FSM for the multi-cycle MIPS datapath: shared ALU, single unified instruction/data memory, IR/A/B/ALUOut/MDR holding registers.
- Decodes OpCode once per instruction and steps the datapath through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and aborts a memory access after a bounded wait.
- Supports R-type, lw, sw, beq and addi; j is optional.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles (mem_ready=0) in a memory state before abort; legal range >=1.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- OpCode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if ALU zero
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR
- RegDst  out  1  0 rt, 1 rd
- MemtoReg  out  1  0 ALUOut, 1 MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- illegal_op  out  1  unsupported opcode seen in DECODE
- mem_err  out  1  memory access aborted by timeout
- instr_done  out  1  last cycle of a completed instruction
- state  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE. All outputs are 0 in IDLE. IDLE always goes to FETCH on the next cycle. Reset mid-instruction abandons it; there is no partial writeback.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready, so the PC advances exactly once.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by OpCode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - anything else -> FETCH with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1, MemRead=1. Waits for mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1. On mem_ready: instr_done=1, goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01, instr_done=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- Latency with zero-wait memory:
  - beq 3 cycles
  - R-type, sw, addi 4 cycles
  - lw 5 cycles
  - each wait cycle adds 1
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the FSM remains there with mem_ready=0.
- Timeout: if the counter equals MEM_TIMEOUT-1 and mem_ready=0, mem_err=1 for that cycle, then go to FETCH.
  - No IRWrite, PCWrite, RegWrite or instr_done is asserted.
  - A lw/sw abort leaves the PC at the next instruction.
  - mem_ready=1 in the timeout cycle means normal completion; mem_err stays 0.
- MemWrite is never asserted together with MemRead.

Optional Feature:
- Macro: MIPS_CTRL_JUMP_EN.
- Defined: OpCode 000010 in DECODE goes to JUMP. JUMP drives PCWrite=1, PCSrc=10, instr_done=1, then goes to FETCH (3 cycles total).
- Undefined: 000010 is illegal (illegal_op pulse, back to FETCH), and PCSrc never equals 10.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum (4-bit)
  - opcode constants: RTYPE, LW, SW, BEQ, ADDI, J
  - ALUOp, ALUSrcB and PCSrc encodings
- Sub-module mem_wait_timer (parameter MEM_TIMEOUT; inputs clr/en; output expired) holds the wait counter.
- The FSM and output decode stay in the top module.

Test Plan:
- R-type with mem_ready held 1 -> states IDLE,FETCH,DECODE,EXEC,ALUWB; RegWrite=1 and RegDst=1 in cycle 4 after FETCH; instr_done single pulse.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> IRWrite and PCWrite exactly one pulse each; total 10 cycles; MemtoReg=1 in MEMWB.
- beq 000100 -> BRANCH has Branch=1, ALUOp=01, PCSrc=01; back in FETCH 3 cycles after fetch start.
- OpCode 111111 -> illegal_op=1 in DECODE only, no RegWrite/MemWrite, next state FETCH. With JUMP_EN, 000010 gives PCWrite=1, PCSrc=10; without it, illegal_op=1.
- sw with mem_ready stuck 0, MEM_TIMEOUT=4 -> MemWrite high 4 cycles, mem_err pulse on the 4th, no instr_done, FETCH next. Repeat with mem_ready=1 on the 4th -> completes, mem_err=0.
- Reset asserted in MEMRD -> next cycle IDLE with all outputs 0, then FETCH; no RegWrite issued.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared state, opcode and datapath-select encodings for the multi-cycle MIPS controller
package mips_mc_pkg;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMMSH = 2'b11} alu_src_b_t;
    typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10} pc_src_t;
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: opcode/memory handshake inputs and datapath control outputs of the controller
interface mips_multicycle_control_if;
    logic [5:0] OpCode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic       illegal_op, mem_err, instr_done;
    logic [3:0] state;
    modport master (
        input  OpCode, mem_ready,
        output PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op, mem_err, instr_done, state
    );
    modport slave (
        output OpCode, mem_ready,
        input  PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op, mem_err, instr_done, state
    );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags the last one allowed
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (reset || clr) ? '0 : en ? cnt + 1'b1 : cnt;
    assign expired = cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore sequencer for the multi-cycle MIPS datapath with memory-wait timeout.
// Define MIPS_CTRL_JUMP_EN to add the j instruction (JUMP state).
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic reset,
    mips_multicycle_control_if.master ctrl
);
    state_t state, nextState;
    logic waitState, expired, timeout;
    assign waitState = state inside {FETCH, MEMRD, MEMWR};
    assign timeout   = waitState && !ctrl.mem_ready && expired;
    // a timeout in FETCH stays in FETCH, so it must clear the counter explicitly
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) timer (
        .clk,
        .reset,
        .clr(timeout || nextState != state),
        .en(waitState && !ctrl.mem_ready),
        .expired
    );
    always_ff @(posedge clk)
        state <= reset ? IDLE : nextState;
    always_comb begin
        nextState       = state;
        ctrl.state      = state;
        ctrl.PCWrite    = 1'b0;
        ctrl.Branch     = 1'b0;
        ctrl.PCSrc      = PC_ALU;
        ctrl.IorD       = 1'b0;
        ctrl.MemRead    = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.IRWrite    = 1'b0;
        ctrl.RegDst     = 1'b0;
        ctrl.MemtoReg   = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.ALUSrcA    = 1'b0;
        ctrl.ALUSrcB    = SRCB_B;
        ctrl.ALUOp      = ALU_ADD;
        ctrl.illegal_op = 1'b0;
        ctrl.mem_err    = timeout;
        ctrl.instr_done = 1'b0;
        case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                ctrl.MemRead = 1'b1;
                ctrl.ALUSrcB = SRCB_4;
                ctrl.IRWrite = ctrl.mem_ready;
                ctrl.PCWrite = ctrl.mem_ready;
                nextState    = ctrl.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.ALUSrcB = SRCB_IMMSH;
                case (ctrl.OpCode)
                    RTYPE:   nextState = EXEC;
                    LW, SW:  nextState = MEMADR;
                    BEQ:     nextState = BRANCH;
                    ADDI:    nextState = ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
                    J:       nextState = JUMP;
`else
                    J: begin
                        nextState       = FETCH;
                        ctrl.illegal_op = 1'b1;
                    end
`endif
                    default: begin
                        nextState       = FETCH;
                        ctrl.illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = SRCB_IMM;
                nextState    = ctrl.OpCode == LW ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.IorD    = 1'b1;
                ctrl.MemRead = 1'b1;
                nextState    = ctrl.mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
            end
            MEMWB: begin
                ctrl.MemtoReg   = 1'b1;
                ctrl.RegWrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                nextState       = FETCH;
            end
            MEMWR: begin
                ctrl.IorD       = 1'b1;
                ctrl.MemWrite   = 1'b1;
                ctrl.instr_done = ctrl.mem_ready;
                nextState       = (ctrl.mem_ready || timeout) ? FETCH : MEMWR;
            end
            EXEC: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUOp   = ALU_FUNCT;
                nextState    = ALUWB;
            end
            ALUWB: begin
                ctrl.RegDst     = 1'b1;
                ctrl.RegWrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                nextState       = FETCH;
            end
            BRANCH: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUOp      = ALU_SUB;
                ctrl.Branch     = 1'b1;
                ctrl.PCSrc      = PC_ALUOUT;
                ctrl.instr_done = 1'b1;
                nextState       = FETCH;
            end
            ADDIEX: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = SRCB_IMM;
                nextState    = ADDIWB;
            end
            ADDIWB: begin
                ctrl.RegWrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                nextState       = FETCH;
            end
`ifdef MIPS_CTRL_JUMP_EN
            JUMP: begin
                ctrl.PCWrite    = 1'b1;
                ctrl.PCSrc      = PC_JUMP;
                ctrl.instr_done = 1'b1;
                nextState       = FETCH;
            end
`endif
            default: nextState = IDLE;
        endcase
    end
endmodule
